// File: rtl/ex_alu_unit.sv
// Execute-stage arithmetic: ALU control decode, 32-bit ALU, branch/PC adder.
// Registered ALU result and zero flag feed the EX/MEM boundary.
module ex_alu_unit (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] data1_i,
    input  logic [31:0] data2_i,
    input  logic [5:0]  funct_i,
    input  logic [1:0]  ALUOp_i,
    output logic [2:0]  ALUCtrl_o,
    output logic [31:0] data_o,
    output logic        Zero_o,
    input  logic [31:0] add_a_i,
    input  logic [31:0] add_b_i,
    output logic [31:0] add_o,
    output logic [31:0] result_q_o,
    output logic        zero_q_o
);

    localparam logic [2:0] CTRL_AND = 3'b000;
    localparam logic [2:0] CTRL_OR  = 3'b001;
    localparam logic [2:0] CTRL_ADD = 3'b010;
    localparam logic [2:0] CTRL_MUL = 3'b011;
    localparam logic [2:0] CTRL_SUB = 3'b110;
    localparam logic [2:0] CTRL_SLT = 3'b111;

    logic [2:0]  alu_ctrl;
    logic [31:0] alu_res;
    logic [31:0] mul_lo;
    logic        slt_bit;
    logic [31:0] result_d, result_q;
    logic        zero_d, zero_q;

    always_comb begin
        alu_ctrl = CTRL_ADD;
        case (ALUOp_i)
            2'b00: alu_ctrl = CTRL_ADD;
            2'b01: alu_ctrl = CTRL_SUB;
            2'b11: alu_ctrl = CTRL_OR;
            default: begin
                case (funct_i)
                    6'b100000: alu_ctrl = CTRL_ADD;
                    6'b100010: alu_ctrl = CTRL_SUB;
                    6'b100100: alu_ctrl = CTRL_AND;
                    6'b100101: alu_ctrl = CTRL_OR;
                    6'b011000: alu_ctrl = CTRL_MUL;
                    6'b101010: alu_ctrl = CTRL_SLT;
                    default:   alu_ctrl = CTRL_ADD;
                endcase
            end
        endcase
    end

    assign mul_lo  = data1_i * data2_i;
    assign slt_bit = $signed(data1_i) < $signed(data2_i);

    // Codes 100 and 101 are unused and produce zero.
    always_comb begin
        alu_res = '0;
        case (alu_ctrl)
            CTRL_AND: alu_res = data1_i & data2_i;
            CTRL_OR:  alu_res = data1_i | data2_i;
            CTRL_ADD: alu_res = data1_i + data2_i;
            CTRL_SUB: alu_res = data1_i - data2_i;
            CTRL_MUL: alu_res = mul_lo;
            CTRL_SLT: alu_res = {31'b0, slt_bit};
            default:  alu_res = '0;
        endcase
    end

    assign ALUCtrl_o = alu_ctrl;
    assign data_o    = alu_res;
    assign Zero_o    = ~|alu_res;
    assign add_o     = add_a_i + add_b_i;

    assign result_d = alu_res;
    assign zero_d   = ~|alu_res;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign result_q_o = result_q;
    assign zero_q_o   = zero_q;

endmodule

// File: tb/tb_ex_alu_unit.sv
// Scoreboard bench for ex_alu_unit: directed vectors, queued expectations,
// monitor checks combinational outputs then the registered copy.
module tb_ex_alu_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] data1_i, data2_i;
    logic [5:0]  funct_i;
    logic [1:0]  ALUOp_i;
    logic [2:0]  ALUCtrl_o;
    logic [31:0] data_o;
    logic        Zero_o;
    logic [31:0] add_a_i, add_b_i, add_o;
    logic [31:0] result_q_o;
    logic        zero_q_o;

    ex_alu_unit dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .data1_i    (data1_i),
        .data2_i    (data2_i),
        .funct_i    (funct_i),
        .ALUOp_i    (ALUOp_i),
        .ALUCtrl_o  (ALUCtrl_o),
        .data_o     (data_o),
        .Zero_o     (Zero_o),
        .add_a_i    (add_a_i),
        .add_b_i    (add_b_i),
        .add_o      (add_o),
        .result_q_o (result_q_o),
        .zero_q_o   (zero_q_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          id;
        logic [2:0]  ctrl;
        logic [31:0] data;
        logic        zero;
        logic [31:0] add;
    } exp_t;

    exp_t qc[$];
    exp_t qr[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Registered check first (captured at the edge just passed), then the
    // combinational check of the vector currently applied.
    always @(negedge clk_i) begin
        exp_t e;
        if (qr.size() > 0) begin
            e = qr.pop_front();
            chk($sformatf("v%0d result_q", e.id), result_q_o, e.data);
            chk($sformatf("v%0d zero_q", e.id), {31'b0, zero_q_o},
                {31'b0, e.zero});
        end
        if (qc.size() > 0) begin
            e = qc.pop_front();
            chk($sformatf("v%0d ctrl", e.id), {29'b0, ALUCtrl_o},
                {29'b0, e.ctrl});
            chk($sformatf("v%0d data", e.id), data_o, e.data);
            chk($sformatf("v%0d zero", e.id), {31'b0, Zero_o},
                {31'b0, e.zero});
            chk($sformatf("v%0d add", e.id), add_o, e.add);
            qr.push_back(e);
        end
    end

    int vid = 0;

    task automatic vec(input logic [1:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] aa, input logic [31:0] ab,
                       input logic [2:0] ectrl, input logic [31:0] edata,
                       input logic ezero, input logic [31:0] eadd);
        exp_t e;
        @(posedge clk_i);
        #2;
        ALUOp_i = op;
        funct_i = fn;
        data1_i = a;
        data2_i = b;
        add_a_i = aa;
        add_b_i = ab;
        vid++;
        e.id   = vid;
        e.ctrl = ectrl;
        e.data = edata;
        e.zero = ezero;
        e.add  = eadd;
        qc.push_back(e);
    endtask

    task automatic reset_pulse(input string tag);
        @(negedge clk_i);
        #1;
        rst_i = 1'b0;
        #1;
        chk({tag, " rst result_q"}, result_q_o, 32'h0);
        chk({tag, " rst zero_q"}, {31'b0, zero_q_o}, 32'h0);
        repeat (2) @(posedge clk_i);
        #1;
        chk({tag, " held result_q"}, result_q_o, 32'h0);
        chk({tag, " held zero_q"}, {31'b0, zero_q_o}, 32'h0);
        @(negedge clk_i);
        #1;
        rst_i = 1'b1;
        #1;
        chk({tag, " release no edge"}, result_q_o, 32'h0);
    endtask

    initial begin
        rst_i   = 1'b0;
        ALUOp_i = 2'b10;
        funct_i = 6'b100000;
        data1_i = 32'd7;
        data2_i = 32'd5;
        add_a_i = 32'h0;
        add_b_i = 32'h0;
        #3;
        chk("reset result_q", result_q_o, 32'h0);
        chk("reset zero_q", {31'b0, zero_q_o}, 32'h0);
        chk("comb in reset", data_o, 32'd12);
        @(negedge clk_i);
        @(negedge clk_i);
        #1;
        rst_i = 1'b1;

        vec(2'b10, 6'b100000, 32'd7, 32'd5, 32'h00400000, 32'd4,
            3'b010, 32'd12, 1'b0, 32'h00400004);
        vec(2'b01, 6'b000000, 32'h1234, 32'h1234, 32'hFFFFFFFC, 32'd8,
            3'b110, 32'h0, 1'b1, 32'h00000004);
        vec(2'b10, 6'b100100, 32'hFFFFFFFE, 32'd3, 32'd1, 32'd2,
            3'b000, 32'd2, 1'b0, 32'd3);
        vec(2'b10, 6'b100101, 32'hFFFFFFFE, 32'd3, 32'h0, 32'h0,
            3'b001, 32'hFFFFFFFF, 1'b0, 32'h0);
        vec(2'b10, 6'b011000, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'd1,
            3'b011, 32'hFFFFFFFA, 1'b0, 32'h0);
        vec(2'b10, 6'b101010, 32'hFFFFFFFE, 32'd3, 32'h10, 32'h20,
            3'b111, 32'd1, 1'b0, 32'h30);
        vec(2'b00, 6'b101010, 32'hFFFFFFFF, 32'd1, 32'h80000000, 32'h80000000,
            3'b010, 32'h0, 1'b1, 32'h0);
        vec(2'b01, 6'b100100, 32'h0, 32'd1, 32'h12345678, 32'h11111111,
            3'b110, 32'hFFFFFFFF, 1'b0, 32'h23456789);
        vec(2'b10, 6'b111111, 32'd2, 32'd3, 32'd100, 32'd4,
            3'b010, 32'd5, 1'b0, 32'd104);
        vec(2'b11, 6'b011000, 32'hF0, 32'h0F, 32'h7FFFFFFF, 32'd1,
            3'b001, 32'hFF, 1'b0, 32'h80000000);
        vec(2'b10, 6'b101010, 32'd3, 32'hFFFFFFFE, 32'd0, 32'd4,
            3'b111, 32'h0, 1'b1, 32'd4);
        vec(2'b10, 6'b100010, 32'd10, 32'd3, 32'hFFFF0000, 32'h0001FFFF,
            3'b110, 32'd7, 1'b0, 32'h0000FFFF);
        vec(2'b10, 6'b011000, 32'h00010000, 32'h00010000, 32'd0, 32'd0,
            3'b011, 32'h0, 1'b1, 32'h0);

        for (int i = 0; i < 10 && (qc.size() > 0 || qr.size() > 0); i++)
            @(posedge clk_i);
        chk("queue drain", qc.size() + qr.size(), 32'd0);

        // Reset discards a captured 12.
        @(posedge clk_i);
        #2;
        ALUOp_i = 2'b10;
        funct_i = 6'b100000;
        data1_i = 32'd7;
        data2_i = 32'd5;
        @(posedge clk_i);
        #1;
        chk("load 12", result_q_o, 32'd12);
        reset_pulse("r1");
        chk("comb after reset", data_o, 32'd12);
        @(posedge clk_i);
        #1;
        chk("reload 12", result_q_o, 32'd12);

        // Reset clears a captured zero flag.
        #1;
        ALUOp_i = 2'b01;
        data1_i = 32'h55;
        data2_i = 32'h55;
        @(posedge clk_i);
        #1;
        chk("load zero_q", {31'b0, zero_q_o}, 32'd1);
        reset_pulse("r2");
        @(posedge clk_i);
        #1;
        chk("reload zero_q", {31'b0, zero_q_o}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule

// File: doc/ex_alu_unit.md
# ex_alu_unit

Execute-stage arithmetic block of the 5-stage pipelined MIPS-subset CPU. Integrates three functions:
- ALU control decode from ALUOp and funct.
- The 32-bit ALU with zero flag.
- A generic 32-bit adder used for PC+4 and branch-target computation.

ALU outputs are combinational for the forwarding and branch paths. A registered copy of the result and zero flag is provided for the EX/MEM boundary.

## Interface
Parameters:
- none; all widths fixed (32-bit datapath, 6-bit funct, 2-bit ALUOp, 3-bit ALU control code)

Ports (one clock; reset is asynchronous and active-low):
- clk_i  in  1  rising-edge clock
- rst_i  in  1  asynchronous, active-low reset
- data1_i  in  32  ALU operand A (forwarded rs value)
- data2_i  in  32  ALU operand B (forwarded rt value or sign-extended immediate)
- funct_i  in  6  instruction funct field (immediate[5:0])
- ALUOp_i  in  2  operation class from control
- ALUCtrl_o  out  3  decoded ALU control code
- data_o  out  32  combinational ALU result
- Zero_o  out  1  combinational, 1 when data_o == 0
- add_a_i  in  32  adder operand A
- add_b_i  in  32  adder operand B
- add_o  out  32  combinational adder sum
- result_q_o  out  32  registered data_o
- zero_q_o  out  1  registered Zero_o

## Operation
ALU control decode (combinational):
- ALUOp 00 -> ADD (010); used by lw/sw/addi.
- ALUOp 01 -> SUB (110); used by beq.
- ALUOp 11 -> OR (001).
- ALUOp 10 -> decode by funct:
  - 100000 ADD 010
  - 100010 SUB 110
  - 100100 AND 000
  - 100101 OR 001
  - 011000 MUL 011
  - 101010 SLT 111
  - any other funct -> ADD 010

ALU operations by control code:
- 000 AND: A & B
- 001 OR: A | B
- 010 ADD: (A + B) mod 2^32
- 110 SUB: (A − B) mod 2^32
- 011 MUL: low 32 bits of A × B
- 111 SLT: 32'd1 if signed(A) < signed(B), else 32'd0
- unused codes (100, 101): result 0

Arithmetic rules:
- No overflow detection or trap; all arithmetic wraps.
- Zero_o = ~|data_o, for every operation.

Adder:
- add_o = (add_a_i + add_b_i) mod 2^32, unsigned.
- Carry-out discarded.
- Independent of the ALU.

Output register:
- On each rising clk_i: result_q_o <= data_o and zero_q_o <= Zero_o.
- No enable; the register loads every cycle.

## Timing
- ALUCtrl_o, data_o, Zero_o and add_o are purely combinational, with zero-cycle latency from any input change.
- result_q_o / zero_q_o reflect the inputs sampled at the previous rising edge (1-cycle latency).
- Reset values: result_q_o = 0, zero_q_o = 0.
- Reset behaviour:
  - rst_i low forces the registers to their reset values immediately, without waiting for a clock edge.
  - Reset asserted mid-operation discards the captured value.
  - On release (rst_i rising), the registers load on the next rising clk_i.
- Combinational outputs are unaffected by rst_i.
- Simultaneous input change and clock edge: the register captures the value settled before the edge (standard setup).

## Test plan
- ALUOp=10, funct=100000, A=7, B=5 -> ALUCtrl_o=010, data_o=12, Zero_o=0; after one clock result_q_o=12.
- ALUOp=01, A=B=0x1234 -> ALUCtrl_o=110, data_o=0, Zero_o=1; then zero_q_o=1 after the next edge.
- ALUOp=10 with funct 100100 / 100101 / 011000 / 101010, A=0xFFFFFFFE (−2), B=3:
  - AND -> 2
  - OR -> 0xFFFFFFFF
  - MUL -> 0xFFFFFFFA
  - SLT -> 1
- Wrap-around: ADD 0xFFFFFFFF+1 -> data_o=0, Zero_o=1; SUB 0−1 -> 0xFFFFFFFF; ALUOp=10 with funct 111111 -> ADD.
- Adder: add_a_i=0x00400000, add_b_i=4 -> add_o=0x00400004; 0xFFFFFFFC+8 -> 0x00000004.
- Reset: load result_q_o=12, then drive rst_i low between clock edges -> result_q_o=0, zero_q_o=0 immediately, held until release plus the first clock edge.
